// File: rtl/fx3_pkg.sv
// Shared definitions for the FX3 command-packet parser: packet layout,
// error codes, FSM states and configuration defaults.
package fx3_pkg;

    localparam logic [31:0] PKT_HEADER = 32'hCAFEB0BA;

    localparam logic [2:0] W_HDR    = 3'd0;
    localparam logic [2:0] W_PKTS   = 3'd1;
    localparam logic [2:0] W_SRC_LO = 3'd2;
    localparam logic [2:0] W_SRC_HI = 3'd3;
    localparam logic [2:0] W_LED    = 3'd4;
    localparam logic [2:0] W_CSUM   = 3'd5;

    localparam logic [63:0] CH_SRC_DEFAULT = {8{8'h08}};

    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_HDR   = 3'd1,
        ERR_SHORT = 3'd2,
        ERR_CSUM  = 3'd3,
        ERR_RANGE = 3'd4
    } err_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BODY,
        S_CHECK,
        S_PEND,
        S_DRAIN
    } state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fx3_cmd_parser_if.sv
// Read-word stream in, committed capture configuration and status out.
interface fx3_cmd_parser_if;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        cfg_hold;
    logic [31:0] packets_to_send;
    logic [63:0] ch_src;
    logic [3:0]  user_led;
    logic        cfg_update;
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;
    logic [2:0]  last_err;

    modport master (
        output rd_valid, rd_data, cfg_hold,
        input  packets_to_send, ch_src, user_led, cfg_update,
               good_cnt, bad_cnt, last_err
    );

    modport slave (
        input  rd_valid, rd_data, cfg_hold,
        output packets_to_send, ch_src, user_led, cfg_update,
               good_cnt, bad_cnt, last_err
    );
endinterface

// File: rtl/ch_src_range_chk.sv
// Flags a word whose four channel-source bytes contain any index above MAX_SRC.
module ch_src_range_chk #(
    parameter int MAX_SRC = 12
) (
    input  logic [31:0] word,
    output logic        any_out
);
    logic [3:0] byte_bad;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte
            assign byte_bad[gi] = word[gi*8 +: 8] > 8'(MAX_SRC);
        end
    endgenerate

    assign any_out = |byte_bad;
endmodule

// File: rtl/fx3_cmd_parser.sv
// Validates FX3 command packets and atomically commits the capture
// configuration, deferring the commit while a write burst holds it.
module fx3_cmd_parser #(
    parameter int          MAX_SRC = 12,
    parameter logic [31:0] HEADER  = fx3_pkg::PKT_HEADER
) (
    input  logic            clk_pll,
    input  logic            reset,
    fx3_cmd_parser_if.slave bus
);
    import fx3_pkg::*;

    state_t      state_reg;
    logic [2:0]  idx_reg;
    logic [31:0] csum_reg;
    logic        range_reg;
    logic [31:0] pkts_shadow_reg;
    logic [63:0] ch_src_shadow_reg;
    logic [3:0]  led_shadow_reg;
    logic [31:0] pkts_reg;
    logic [63:0] ch_src_reg;
    logic [3:0]  led_reg;
    logic        cfg_update_reg;
    logic [15:0] good_cnt_reg;
    logic [15:0] bad_cnt_reg;
    err_t        last_err_reg;
    logic        src_bad;

    // One checker serves both channel-map words; its result is only used for them.
    ch_src_range_chk #(.MAX_SRC(MAX_SRC)) u_range_chk (
        .word    (bus.rd_data),
        .any_out (src_bad)
    );

    always_ff @(posedge clk_pll) begin
        if (reset) begin
            state_reg         <= S_IDLE;
            idx_reg           <= W_HDR;
            csum_reg          <= '0;
            range_reg         <= 1'b0;
            pkts_shadow_reg   <= '0;
            ch_src_shadow_reg <= '0;
            led_shadow_reg    <= '0;
            pkts_reg          <= '0;
            ch_src_reg        <= CH_SRC_DEFAULT;
            led_reg           <= 4'b1111;
            cfg_update_reg    <= 1'b0;
            good_cnt_reg      <= '0;
            bad_cnt_reg       <= '0;
            last_err_reg      <= ERR_NONE;
        end else begin
            cfg_update_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (bus.rd_valid) begin
                        if (bus.rd_data == HEADER) begin
                            csum_reg  <= '0;
                            range_reg <= 1'b0;
                            idx_reg   <= W_PKTS;
                            state_reg <= S_BODY;
                        end else begin
                            bad_cnt_reg  <= sat_inc(bad_cnt_reg);
                            last_err_reg <= ERR_HDR;
                            state_reg    <= S_DRAIN;
                        end
                    end
                end
                S_BODY: begin
                    if (bus.rd_valid) begin
                        csum_reg <= csum_reg ^ bus.rd_data;
                        case (idx_reg)
                            W_PKTS:   pkts_shadow_reg          <= bus.rd_data;
                            W_SRC_LO: ch_src_shadow_reg[31:0]  <= bus.rd_data;
                            W_SRC_HI: ch_src_shadow_reg[63:32] <= bus.rd_data;
                            default:  led_shadow_reg           <= bus.rd_data[3:0];
                        endcase
                        if ((idx_reg == W_SRC_LO || idx_reg == W_SRC_HI) && src_bad) begin
                            range_reg <= 1'b1;
                        end
                        if (idx_reg == W_LED) begin
                            state_reg <= S_CHECK;
                        end
                        idx_reg <= idx_reg + 3'd1;
                    end else begin
                        bad_cnt_reg  <= sat_inc(bad_cnt_reg);
                        last_err_reg <= ERR_SHORT;
                        state_reg    <= S_IDLE;
                    end
                end
                S_CHECK: begin
                    if (bus.rd_valid) begin
                        if (bus.rd_data != csum_reg) begin
                            bad_cnt_reg  <= sat_inc(bad_cnt_reg);
                            last_err_reg <= ERR_CSUM;
                            state_reg    <= S_DRAIN;
                        end else if (range_reg) begin
                            bad_cnt_reg  <= sat_inc(bad_cnt_reg);
                            last_err_reg <= ERR_RANGE;
                            state_reg    <= S_DRAIN;
                        end else begin
                            state_reg <= S_PEND;
                        end
                    end else begin
                        bad_cnt_reg  <= sat_inc(bad_cnt_reg);
                        last_err_reg <= ERR_SHORT;
                        state_reg    <= S_IDLE;
                    end
                end
                S_PEND: begin
                    // Incoming words are dropped here; the drain state absorbs the rest.
                    if (!bus.cfg_hold) begin
                        pkts_reg       <= pkts_shadow_reg;
                        ch_src_reg     <= ch_src_shadow_reg;
                        led_reg        <= ~led_shadow_reg;
                        cfg_update_reg <= 1'b1;
                        good_cnt_reg   <= sat_inc(good_cnt_reg);
                        state_reg      <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!bus.rd_valid) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.packets_to_send = pkts_reg;
    assign bus.ch_src          = ch_src_reg;
    assign bus.user_led        = led_reg;
    assign bus.cfg_update      = cfg_update_reg;
    assign bus.good_cnt        = good_cnt_reg;
    assign bus.bad_cnt         = bad_cnt_reg;
    assign bus.last_err        = last_err_reg;
endmodule

// File: tb/tb_fx3_cmd_parser.sv
// Scoreboard bench for fx3_cmd_parser: expected commits/rejections are queued
// as stimulus is driven and matched against DUT events with their cycle.
module tb_fx3_cmd_parser;

    typedef struct {
        logic        commit;
        logic [31:0] pkts;
        logic [63:0] ch;
        logic [3:0]  led;
        logic [2:0]  err;
        logic [15:0] cnt;
        int          cyc;
    } exp_t;

    logic clk_pll = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_pll = ~clk_pll;

    fx3_cmd_parser_if bus();

    fx3_cmd_parser dut (
        .clk_pll (clk_pll),
        .reset   (reset),
        .bus     (bus)
    );

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        mon_en = 1'b0;
    logic [15:0] bad_prev = '0;

    logic [31:0] mdl_pkts = '0;
    logic [63:0] mdl_ch   = {8{8'h08}};
    logic [3:0]  mdl_led  = 4'b1111;
    logic [15:0] mdl_good = '0;
    logic [15:0] mdl_bad  = '0;
    logic [2:0]  mdl_err  = '0;

    always @(posedge clk_pll) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic push_commit(input logic [31:0] w [8], input int lat);
        exp_t e;
        mdl_good = sat(mdl_good);
        e.commit = 1'b1;
        e.pkts   = w[1];
        e.ch     = {w[3], w[2]};
        e.led    = ~w[4][3:0];
        e.err    = '0;
        e.cnt    = mdl_good;
        e.cyc    = cyc + lat;
        exp_q.push_back(e);
    endtask

    task automatic push_reject(input logic [2:0] err);
        exp_t e;
        mdl_bad  = sat(mdl_bad);
        mdl_err  = err;
        e.commit = 1'b0;
        e.pkts   = '0;
        e.ch     = '0;
        e.led    = '0;
        e.err    = err;
        e.cnt    = mdl_bad;
        e.cyc    = cyc + 1;
        exp_q.push_back(e);
    endtask

    // kind: 0 no event, 1 commit (latency 2), 2 reject. trig==n means the gap cycle.
    task automatic send(input logic [31:0] w [8], input int n, input int trig,
                        input int kind, input logic [2:0] err);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_pll);
            bus.rd_valid = 1'b1;
            bus.rd_data  = w[i];
            if (i == trig && kind == 1) push_commit(w, 2);
            if (i == trig && kind == 2) push_reject(err);
        end
        @(negedge clk_pll);
        bus.rd_valid = 1'b0;
        bus.rd_data  = '0;
        if (trig == n && kind == 2) push_reject(err);
    endtask

    task automatic mk_pkt(input logic [31:0] p, lo, hi, led, output logic [31:0] w [8]);
        w[0] = 32'hCAFEB0BA;
        w[1] = p;
        w[2] = lo;
        w[3] = hi;
        w[4] = led;
        w[5] = p ^ lo ^ hi ^ led;
        w[6] = 32'h11111111;
        w[7] = 32'h22222222;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk_pll);
    endtask

    task automatic check_cfg(input string tag);
        #1;
        chk({tag, "_pkts"}, 64'(bus.packets_to_send), 64'(mdl_pkts));
        chk({tag, "_ch"},   bus.ch_src,                mdl_ch);
        chk({tag, "_led"},  64'(bus.user_led),         64'(mdl_led));
        chk({tag, "_good"}, 64'(bus.good_cnt),         64'(mdl_good));
        chk({tag, "_bad"},  64'(bus.bad_cnt),          64'(mdl_bad));
        chk({tag, "_err"},  64'(bus.last_err),         64'(mdl_err));
        chk({tag, "_qlen"}, 64'(exp_q.size()),         64'd0);
    endtask

    // Monitor: every cfg_update pulse and every bad_cnt change pops one expectation.
    always @(negedge clk_pll) begin
        exp_t e;
        if (mon_en && bus.cfg_update) begin
            chk("update_expected", 64'(exp_q.size() != 0 && exp_q[0].commit), 64'd1);
            if (exp_q.size() != 0 && exp_q[0].commit) begin
                e = exp_q.pop_front();
                chk("upd_pkts", 64'(bus.packets_to_send), 64'(e.pkts));
                chk("upd_ch",   bus.ch_src,                e.ch);
                chk("upd_led",  64'(bus.user_led),         64'(e.led));
                chk("upd_good", 64'(bus.good_cnt),         64'(e.cnt));
                chk("upd_cyc",  64'(cyc),                  64'(e.cyc));
                mdl_pkts = e.pkts;
                mdl_ch   = e.ch;
                mdl_led  = e.led;
                $display("cyc %0d commit pkts=%0d ch=%h led=%b good=%0d",
                         cyc, bus.packets_to_send, bus.ch_src, bus.user_led, bus.good_cnt);
            end
        end
        if (mon_en && bus.bad_cnt != bad_prev) begin
            chk("reject_expected", 64'(exp_q.size() != 0 && !exp_q[0].commit), 64'd1);
            if (exp_q.size() != 0 && !exp_q[0].commit) begin
                e = exp_q.pop_front();
                chk("rej_err", 64'(bus.last_err), 64'(e.err));
                chk("rej_bad", 64'(bus.bad_cnt),  64'(e.cnt));
                chk("rej_cyc", 64'(cyc),          64'(e.cyc));
                $display("cyc %0d reject err=%0d bad=%0d", cyc, bus.last_err, bus.bad_cnt);
            end
        end
        bad_prev = bus.bad_cnt;
    end

    initial begin
        logic [31:0] w [8];
        logic [31:0] wb [8];

        bus.rd_valid = 1'b0;
        bus.rd_data  = '0;
        bus.cfg_hold = 1'b0;
        settle(3);
        reset = 1'b0;
        check_cfg("reset");
        chk("reset_upd", 64'(bus.cfg_update), 64'd0);
        mon_en = 1'b1;

        // Valid packet, commit two cycles after the checksum word.
        mk_pkt(32'd3, 32'h03020100, 32'h07060504, 32'h5, w);
        send(w, 6, 5, 1, 3'd0);
        settle(4);
        check_cfg("valid");

        // Bad header followed by five words.
        wb = '{32'hDEADBEEF, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 32'd0};
        send(wb, 6, 0, 2, 3'd1);
        settle(3);
        check_cfg("badhdr");

        // Short burst then a valid packet after a single idle cycle.
        mk_pkt(32'd9, 32'h01020304, 32'h05060708, 32'h0, wb);
        send(wb, 4, 4, 2, 3'd2);
        mk_pkt(32'd7, 32'h0C0B0A09, 32'h01000C0B, 32'hA, w);
        send(w, 7, 5, 1, 3'd0);
        settle(4);
        check_cfg("short_next");

        // Checksum off by one bit.
        mk_pkt(32'd100, 32'h00000000, 32'h00000000, 32'h0, wb);
        wb[5] = wb[5] ^ 32'h1;
        send(wb, 6, 5, 2, 3'd3);
        settle(3);
        check_cfg("csum");

        // Channel byte 13 is out of range.
        mk_pkt(32'd200, 32'h0302010D, 32'h07060504, 32'h3, wb);
        send(wb, 6, 5, 2, 3'd4);
        settle(3);
        check_cfg("range");

        // Deferred commit; a burst arriving during the hold is discarded.
        bus.cfg_hold = 1'b1;
        mk_pkt(32'd42, 32'h0A0A0B0B, 32'h0C0C0000, 32'h6, w);
        send(w, 6, -1, 0, 3'd0);
        wb = '{32'hCAFEB0BA, 32'd5, 32'd6, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        send(wb, 3, -1, 0, 3'd0);
        repeat (4) begin
            @(negedge clk_pll);
            #1;
            chk("hold_pkts", 64'(bus.packets_to_send), 64'(mdl_pkts));
            chk("hold_led",  64'(bus.user_led),        64'(mdl_led));
        end
        @(negedge clk_pll);
        push_commit(w, 1);
        bus.cfg_hold = 1'b0;
        settle(4);
        check_cfg("hold");

        // Saturation of the rejection counter.
        mon_en = 1'b0;
        @(negedge clk_pll);
        force dut.bad_cnt_reg = 16'hFFFE;
        @(negedge clk_pll);
        release dut.bad_cnt_reg;
        settle(2);
        mdl_bad = 16'hFFFE;
        mon_en  = 1'b1;
        wb = '{32'h12345678, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        send(wb, 1, 0, 2, 3'd1);
        settle(2);
        check_cfg("sat_ffff");
        mk_pkt(32'd1, 32'h0, 32'h0, 32'h0, wb);
        wb[5] = ~wb[5];
        send(wb, 6, -1, 0, 3'd0);
        mdl_err = 3'd3;
        settle(3);
        check_cfg("sat_hold");

        // Reset in the middle of a packet; the tail is then rejected as a bad header.
        mk_pkt(32'd5, 32'h00010203, 32'h04050607, 32'h9, w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_pll);
            bus.rd_valid = 1'b1;
            bus.rd_data  = w[i];
        end
        @(negedge clk_pll);
        mon_en = 1'b0;
        reset  = 1'b1;
        bus.rd_data = w[3];
        @(negedge clk_pll);
        mdl_pkts = '0;
        mdl_ch   = {8{8'h08}};
        mdl_led  = 4'b1111;
        mdl_good = '0;
        mdl_bad  = '0;
        mdl_err  = '0;
        check_cfg("midrst");
        chk("midrst_upd", 64'(bus.cfg_update), 64'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        push_reject(3'd1);
        for (int i = 4; i < 6; i++) begin
            @(negedge clk_pll);
            bus.rd_data = w[i];
        end
        @(negedge clk_pll);
        bus.rd_valid = 1'b0;
        settle(3);
        check_cfg("post_rst");

        // Recovery: a fresh valid packet is accepted.
        mk_pkt(32'd11, 32'h0C000102, 32'h03040506, 32'hF, w);
        send(w, 6, 5, 1, 3'd0);
        settle(4);
        check_cfg("recover");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
